// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states and
// the select/cause encodings driven onto the datapath.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_REG    = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'b00,
        PC_ALUOUT  = 2'b01,
        PC_ALURES  = 2'b10,
        PC_TRAPVEC = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        RES_LINK   = 2'b00,
        RES_ALUOUT = 2'b01,
        RES_IMM    = 2'b10,
        RES_LOAD   = 2'b11
    } result_sel_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'b00,
        TC_ILLEGAL = 2'b01,
        TC_TIMEOUT = 2'b10
    } trap_cause_t;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; expired flags the last allowed wait cycle.
// TIMEOUT=0 disables expiry entirely.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB against a
// shared variable-latency memory port and traps on illegal opcodes or timeouts.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter bit          EN_TRAP  = 1'b1,
    parameter int unsigned ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          instr_opcode,
    input  logic                mem_ready,
    input  logic                branch_taken,
    input  logic                trap_clear,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [1:0]          result_sel,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_retired,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    state_t      state_q, state_d;
    trap_cause_t cause_q, cause_d;
    logic [6:0]  op_q;
    logic [1:0]  alu_cls;
    logic        expired;
    logic        timer_run;
    logic        timer_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= TC_NONE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (ir_write) begin
                op_q <= instr_opcode;
            end
        end
    end

    // Wait time is only charged while a request is outstanding and unanswered.
    assign timer_run = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
    assign timer_clr = mem_ready || (state_d != state_q);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (timer_run),
        .clr     (timer_clr),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        reg_write     = 1'b0;
        result_sel    = RES_LINK;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_cls       = ALU_ADD;
        instr_retired = 1'b0;
        trap          = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (expired) begin
                    cause_d = TC_TIMEOUT;
                    state_d = TRAP;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (is_legal(op_q)) begin
                    state_d = EXEC;
                end else if (EN_TRAP) begin
                    cause_d = TC_ILLEGAL;
                    state_d = TRAP;
                end else begin
                    instr_retired = 1'b1;
                    state_d       = FETCH;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_REG: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_RS2;
                        alu_cls   = ALU_FUNCT;
                        state_d   = WB;
                    end
                    OP_IMM: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        alu_cls   = ALU_FUNCT;
                        state_d   = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        state_d   = MEM;
                    end
                    OP_AUIPC: begin
                        alu_src_a = SRCA_OLDPC;
                        alu_src_b = SRCB_IMM;
                        state_d   = WB;
                    end
                    OP_LUI: state_d = WB;
                    OP_BRANCH: begin
                        alu_src_a     = SRCA_RS1;
                        alu_src_b     = SRCB_RS2;
                        alu_cls       = ALU_BRANCH;
                        pc_write      = branch_taken;
                        pc_src        = PC_ALUOUT;
                        instr_retired = 1'b1;
                        state_d       = FETCH;
                    end
                    OP_JAL: begin
                        pc_write      = 1'b1;
                        pc_src        = PC_ALUOUT;
                        reg_write     = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = FETCH;
                    end
                    OP_JALR: begin
                        alu_src_a     = SRCA_RS1;
                        alu_src_b     = SRCB_IMM;
                        pc_write      = 1'b1;
                        pc_src        = PC_ALURES;
                        reg_write     = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        instr_retired = 1'b1;
                        state_d       = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (expired) begin
                    cause_d = TC_TIMEOUT;
                    state_d = TRAP;
                end
            end
            WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = FETCH;
                if (op_q == OP_LOAD) begin
                    result_sel = RES_LOAD;
                end else if (op_q == OP_LUI) begin
                    result_sel = RES_IMM;
                end else begin
                    result_sel = RES_ALUOUT;
                end
            end
            TRAP: begin
                trap = 1'b1;
                if (trap_clear) begin
                    pc_write = 1'b1;
                    pc_src   = PC_TRAPVEC;
                    cause_d  = TC_NONE;
                    state_d  = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_op     = ALU_OP_W'(alu_cls);
    assign trap_cause = cause_q;

endmodule
